// File: rtl/spi_controller.sv
// SPI controller, mode 0 (CPOL=0, CPHA=0), MSB first.
//
// Issues 16-bit register frames {rw, addr[6:0], data[7:0]} to an SPI peripheral.
// A write frame loads the peripheral register at addr. A read frame captures the
// 8 bits the peripheral returns on cipo during the data byte.
//
// Frame timeline, counted in clk edges after the accept edge (D = CLK_DIV):
//   0        ncs falls, copi = frame[15]
//   D        first sclk rise
//   2D*(p+1) sclk falls for period p; cipo sampled, copi advances
//   33D      hold phase begins (sclk low, ncs still low)
//   34D      ncs rises
//   34D+CS_GAP+1  done pulse, busy drops
//
// Ports:
//   clk, rst_n       system clock and asynchronous active-low reset
//   start            frame request, accepted only while busy is low
//   rw, addr, wdata  frame fields, sampled together with start
//   cipo             serial data from the peripheral
//   sclk, copi, ncs  SPI bus outputs (all registered)
//   busy             high from the accept edge until done
//   done             one-cycle pulse at frame completion
//   rdata            data from the most recent completed read frame
module spi_controller #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  input  logic       cipo,
  output logic       sclk,
  output logic       copi,
  output logic       ncs,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata
);

  // One counter serves both the SCLK phases and the chip-select gap.
  localparam int unsigned CntMax = (CLK_DIV - 1 > CS_GAP) ? CLK_DIV - 1 : CS_GAP;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] PhaseLast = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] GapLast   = CntW'(CS_GAP);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StHold,
    StGap
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [4:0]      bit_q, bit_d;
  logic [15:0]     shift_q, shift_d;
  logic            rw_q, rw_d;
  logic [7:0]      rx_q, rx_d;
  logic            sclk_q, sclk_d;
  logic            copi_q, copi_d;
  logic            ncs_q, ncs_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [7:0]      rdata_q, rdata_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    rw_d    = rw_q;
    rx_d    = rx_q;
    sclk_d  = sclk_q;
    copi_d  = copi_q;
    ncs_d   = ncs_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          shift_d = {rw, addr, wdata};
          rw_d    = rw;
          copi_d  = rw;
          ncs_d   = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = StSetup;
        end
      end

      StSetup: begin
        if (cnt_q == PhaseLast) begin
          cnt_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b1;
          state_d = StShift;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StShift: begin
        if (cnt_q == PhaseLast) begin
          cnt_d = '0;
          if (sclk_q) begin
            // End of a high phase: sample cipo, drop sclk, present the next bit.
            // The shifter back-fills zeros, so copi is 0 after the 16th bit.
            sclk_d  = 1'b0;
            rx_d    = {rx_q[6:0], cipo};
            copi_d  = shift_q[14];
            shift_d = {shift_q[14:0], 1'b0};
            bit_d   = bit_q + 5'd1;
          end else if (bit_q == 5'd16) begin
            state_d = StHold;
          end else begin
            sclk_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StHold: begin
        if (cnt_q == PhaseLast) begin
          cnt_d   = '0;
          ncs_d   = 1'b1;
          state_d = StGap;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StGap: begin
        if (cnt_q == GapLast) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
          // rx holds the last eight samples, i.e. the data byte of the frame.
          if (!rw_q) begin
            rdata_d = rx_q;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      rw_q    <= 1'b0;
      rx_q    <= '0;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
      ncs_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      rw_q    <= rw_d;
      rx_q    <= rx_d;
      sclk_q  <= sclk_d;
      copi_q  <= copi_d;
      ncs_q   <= ncs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  assign sclk  = sclk_q;
  assign copi  = copi_q;
  assign ncs   = ncs_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: a timeline model predicts every output on every
// cycle from the frame's accept edge; an SPI peripheral model with five
// registers answers reads and records writes.
module tb_spi_controller;

  localparam int D   = 4;
  localparam int G   = 2;
  localparam int LAT = 34 * D + G + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       cipo = 1'b0;
  logic       sclk, copi, ncs, busy, done;
  logic [7:0] rdata;

  logic       start2 = 1'b0;
  logic       sclk2, copi2, ncs2, busy2, done2;
  logic [7:0] rdata2;

  always #5 clk = ~clk;

  spi_controller #(.CLK_DIV(D), .CS_GAP(G)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .rw    (rw),
    .addr  (addr),
    .wdata (wdata),
    .cipo  (cipo),
    .sclk  (sclk),
    .copi  (copi),
    .ncs   (ncs),
    .busy  (busy),
    .done  (done),
    .rdata (rdata)
  );

  spi_controller #(.CLK_DIV(2), .CS_GAP(2)) u_dut_div2 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start2),
    .rw    (1'b1),
    .addr  (7'h01),
    .wdata (8'h5A),
    .cipo  (1'b0),
    .sclk  (sclk2),
    .copi  (copi2),
    .ncs   (ncs2),
    .busy  (busy2),
    .done  (done2),
    .rdata (rdata2)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- peripheral model ----------------
  logic [7:0]  pregs [5];
  logic [15:0] p_sh;
  logic [15:0] p_last;
  int          p_cnt;
  logic        p_sclk;
  logic        p_ncs;
  logic [7:0]  p_rd;

  function automatic logic [7:0] reg_value(input logic [6:0] a, input logic [7:0] r0,
                                           input logic [7:0] r1, input logic [7:0] r2,
                                           input logic [7:0] r3, input logic [7:0] r4);
    case (a)
      7'd0:    return r0;
      7'd1:    return r1;
      7'd2:    return r2;
      7'd3:    return r3;
      7'd4:    return r4;
      default: return {1'b1, a};
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 5; i++) pregs[i] = '0;
    p_sh = '0; p_last = '0; p_cnt = 0; p_sclk = 1'b0; p_ncs = 1'b1; p_rd = '0;
    forever begin
      @(negedge clk);
      if (p_ncs && !ncs) begin
        p_cnt = 0;
        p_sh  = '0;
      end
      if (!ncs && sclk && !p_sclk) begin
        p_sh = {p_sh[14:0], copi};
        p_cnt++;
        if (p_cnt == 8 && !p_sh[7])
          p_rd = reg_value(p_sh[6:0], pregs[0], pregs[1], pregs[2], pregs[3], pregs[4]);
        if (p_cnt == 16) begin
          p_last = p_sh;
          if (p_sh[15] && p_sh[14:8] < 7'd5) pregs[p_sh[10:8]] = p_sh[7:0];
        end
      end
      if (!ncs && !sclk && p_cnt >= 8 && p_cnt < 16) cipo = p_rd[15 - p_cnt];
      p_sclk = sclk;
      p_ncs  = ncs;
    end
  end

  // ---------------- timeline model + per-cycle compare ----------------
  int          m_k = -1;
  logic [15:0] m_frame = '0;
  logic [7:0]  m_rdata = '0;
  logic [7:0]  m_regs [5];
  int          done_cnt = 0;
  int          ncs_falls = 0;
  int          low_run = 0, high_run = 0, last_low = 0, last_high = 0;
  logic        prev_ncs = 1'b1;

  function automatic logic [12:0] model_out(input int k, input logic [15:0] f,
                                            input logic [7:0] rd);
    logic n, s, c, b, dn;
    n  = !(k >= 0 && k < 34 * D);
    s  = (k >= D && k < 33 * D) && (((k - D) / D) % 2 == 0);
    c  = (k >= 0 && k < 32 * D) ? f[15 - k / (2 * D)] : 1'b0;
    b  = (k >= 0 && k < LAT);
    dn = (k == LAT);
    return {n, s, c, b, dn, rd};
  endfunction

  initial begin
    logic       s_start, s_rw, s_rst;
    logic [6:0] s_addr;
    logic [7:0] s_wdata;
    for (int i = 0; i < 5; i++) m_regs[i] = '0;
    forever begin
      @(posedge clk);
      s_start = start; s_rw = rw; s_addr = addr; s_wdata = wdata; s_rst = rst_n;
      #1;
      if (!s_rst) begin
        m_k     = -1;
        m_rdata = '0;
      end else if (m_k >= 0 && m_k < LAT) begin
        m_k++;
        if (m_k == LAT) begin
          if (m_frame[15]) begin
            if (m_frame[14:8] < 7'd5) m_regs[m_frame[10:8]] = m_frame[7:0];
          end else begin
            m_rdata = reg_value(m_frame[14:8], m_regs[0], m_regs[1], m_regs[2], m_regs[3],
                                m_regs[4]);
          end
        end
      end else if (s_start) begin
        m_k     = 0;
        m_frame = {s_rw, s_addr, s_wdata};
      end else begin
        m_k = -1;
      end
      check("cycle_ncs_sclk_copi_busy_done_rdata", {19'd0, ncs, sclk, copi, busy, done, rdata},
            {19'd0, model_out(m_k, m_frame, m_rdata)});
      if (done === 1'b1) done_cnt++;
      if (ncs === 1'b0) begin
        if (prev_ncs) begin
          last_high = high_run;
          ncs_falls++;
        end
        high_run = 0;
        low_run++;
      end else begin
        if (!prev_ncs) last_low = low_run;
        low_run = 0;
        high_run++;
      end
      prev_ncs = ncs;
    end
  end

  // ---------------- stimulus ----------------
  task automatic frame(input logic r, input logic [6:0] a, input logic [7:0] d,
                       input bit noise, output int lat);
    int n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 2000) check("wait_idle_timeout", 1, 0);
    rw = r; addr = a; wdata = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 1000) begin
      if (noise) begin
        rw = 1'($urandom); addr = 7'($urandom); wdata = 8'($urandom);
        start = ($urandom_range(0, 7) == 0);
      end
      @(posedge clk); #1; lat++;
    end
    start = 1'b0;
    if (lat >= 1000) check("frame_done_timeout", 1, 0);
  endtask

  initial begin
    int lat, n, seen, rises, dn_before, low2, first_rise, period;
    logic prev_s;
    logic [7:0] exp_regs [5];

    #2 rst_n = 1'b0;
    #10;
    check("reset_ncs", ncs, 1'b1);
    check("reset_sclk", sclk, 1'b0);
    check("reset_copi", copi, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_rdata", rdata, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // CLK_DIV=2 instance: latency, ncs width, sclk period
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    lat = 0; low2 = (ncs2 == 1'b0) ? 1 : 0; first_rise = -1; period = -1; prev_s = sclk2;
    while (done2 !== 1'b1 && lat < 500) begin
      @(posedge clk); #1; lat++;
      if (ncs2 == 1'b0) low2++;
      if (sclk2 && !prev_s) begin
        if (first_rise >= 0 && period < 0) period = lat - first_rise;
        if (first_rise < 0) first_rise = lat;
      end
      prev_s = sclk2;
    end
    check("div2_latency", lat, 71);
    check("div2_ncs_low", low2, 68);
    check("div2_sclk_period", period, 4);

    // basic write
    frame(1'b1, 7'h00, 8'hF0, 1'b0, lat);
    check("wr0_latency", lat, 139);
    check("wr0_frame_bits", p_last, 16'h80F0);
    check("wr0_reg0", pregs[0], 8'hF0);
    check("wr0_ncs_low", last_low, 136);
    check("wr0_done_count", done_cnt, 1);

    // read back, rdata survives a later write
    frame(1'b1, 7'h04, 8'hA5, 1'b0, lat);
    frame(1'b0, 7'h04, 8'h00, 1'b0, lat);
    check("rd4_rdata", rdata, 8'hA5);
    frame(1'b1, 7'h02, 8'h77, 1'b1, lat);
    check("rdata_kept_after_write", rdata, 8'hA5);
    check("wr2_reg2", pregs[2], 8'h77);

    // start held through two frames
    dn_before = ncs_falls;
    rw = 1'b1; addr = 7'h01; wdata = 8'h11; start = 1'b1;
    seen = 0; n = 0;
    while (seen < 2 && n < 600) begin
      @(posedge clk); #1; n++;
      if (done === 1'b1) seen++;
    end
    start = 1'b0;
    check("held_two_dones", seen, 2);
    check("held_two_ncs_falls", ncs_falls - dn_before, 2);
    check("held_cs_gap_min", last_high >= G, 1);
    check("held_reg1", pregs[1], 8'h11);

    // reset at the 8th sclk rise of a write to reg3
    @(posedge clk); #1;
    rw = 1'b1; addr = 7'h03; wdata = 8'h3C; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dn_before = done_cnt; rises = 0; n = 0; prev_s = sclk;
    while (rises < 8 && n < 1000) begin
      @(posedge clk); #1; n++;
      if (sclk && !prev_s) rises++;
      prev_s = sclk;
    end
    check("abort_reached_rise8", rises, 8);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ncs", ncs, 1'b1);
    check("abort_sclk", sclk, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_rdata", rdata, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - dn_before, 0);
    check("abort_reg3_untouched", pregs[3], 8'h00);
    frame(1'b1, 7'h03, 8'h3C, 1'b0, lat);
    check("clean_frame_bits", p_last, 16'h833C);
    check("clean_reg3", pregs[3], 8'h3C);

    // back-to-back writes to all five registers
    for (int i = 0; i < 5; i++) begin
      exp_regs[i] = 8'($urandom);
      frame(1'b1, 7'(i), exp_regs[i], 1'b1, lat);
    end
    for (int i = 0; i < 5; i++) check("b2b_reg", pregs[i], exp_regs[i]);

    // random traffic with input noise mid-frame
    for (int i = 0; i < 20; i++) begin
      frame(1'($urandom), 7'($urandom_range(0, 7)), 8'($urandom), 1'b1, lat);
      check("rand_latency", lat, LAT);
    end

    repeat (5) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
